mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Round-robin arbiter sharing one memory port between NUM_CORES cores, each using the core's request/response memory handshake (request, wren, address, writedata in; readdata, response out).
- Sits between the core array and the shared data memory.
- Serves one transaction at a time.
- Latches the winner's command and routes the memory response back to that core only.

Parameters:
- WIDTH, 32, data/address width.
- NUM_CORES, 4, number of requesting cores (2..16).
- IDX_W, 2, grant index width, must equal ceil(log2(NUM_CORES)).
- TIMEOUT_CYCLES, 255, max cycles waiting for mem_response (used only with ARB_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  synchronous active-low reset.
- core_request  in  NUM_CORES  per-core request level.
- core_wren  in  NUM_CORES  per-core write enable.
- core_address  in  NUM_CORES*WIDTH  packed addresses, core i at bits [i*WIDTH +: WIDTH].
- core_writedata  in  NUM_CORES*WIDTH  packed write data.
- core_readdata  out  WIDTH  shared read data, valid with core_response.
- core_response  out  NUM_CORES  one-hot, one-cycle completion pulse.
- core_error  out  1  valid with core_response; timeout flag.
- mem_request  out  1  request to memory.
- mem_wren  out  1  write enable to memory.
- mem_address  out  WIDTH  address to memory.
- mem_writedata  out  WIDTH  write data to memory.
- mem_readdata  in  WIDTH  memory read data.
- mem_response  in  1  memory completion, sampled when mem_request=1.
- grant_idx  out  IDX_W  index of the core being served.
- busy  out  1  high in BUSY and DONE.

Behaviour:
- Reset: all outputs 0, state IDLE, rr_ptr=0, timeout counter 0.
  - Reset mid-transaction drops mem_request on the next edge and discards any in-flight response.
  - The memory side must tolerate a dropped request.
- Core protocol:
  - A core holds request, wren, address and writedata stable until it samples its core_response=1.
  - It deasserts request on that same edge.
- States are IDLE, BUSY and DONE.
- IDLE:
  - If any core_request bit is set, select the first set bit searching rr_ptr, rr_ptr+1, ... modulo NUM_CORES.
  - On the edge: latch that core's wren/address/writedata into the mem_* registers, set mem_request=1, set grant_idx, go to BUSY.
  - Latency: request seen at edge t gives mem_request=1 from t+1.
  - With no request, stay in IDLE.
- BUSY:
  - mem_* outputs are held constant.
  - On an edge with mem_response=1: capture mem_readdata into core_readdata, set core_response[grant_idx]=1, clear mem_request, rr_ptr<=grant_idx+1 (wrap at NUM_CORES), go to DONE.
  - Writes complete the same way; core_readdata is captured regardless and is don't-care for writes.
- DONE:
  - One cycle; core_response is high.
  - Next edge: core_response<=0, go to IDLE. No new grant is issued from DONE.
  - This guarantees the served core's stale request is never re-granted.
- Throughput: minimum 3 cycles per transaction plus memory latency.
- Fairness: a core waits at most NUM_CORES-1 transactions.
- Requests are sampled only in IDLE. Deasserting core_request while a different core is served has no effect.
- Simultaneous requests are resolved purely by rr_ptr order.
- mem_response while in IDLE or DONE is ignored.
- core_error is 0 unless ARB_TIMEOUT_EN is defined.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to BUSY and increments every BUSY cycle.
  - When it reaches TIMEOUT_CYCLES without mem_response: clear mem_request, set core_readdata={WIDTH{1'b1}}, pulse core_response[grant_idx] with core_error=1, advance rr_ptr, go to DONE.
  - mem_response on the same edge as the timeout wins (normal completion, core_error=0).
- Undefined: no counter; BUSY waits indefinitely; core_error tied 0.

Test Plan:
- Reset: hold reset_n=0 with core_request=4'b1111 -> mem_request=0, core_response=0, grant_idx=0. Release -> first grant to core 0 one cycle later.
- Single read: core 2 reads address 0x00000010; memory responds 3 cycles after mem_request with 0x00000002 -> mem_address=0x10, mem_wren=0. Core_response=4'b0100 for exactly one cycle with core_readdata=0x2, then IDLE.
- Round-robin: all four cores request continuously, each dropping request after its response and re-requesting 2 cycles later -> grant order 0,1,2,3,0. No core is granted twice in a row.
- Write passthrough: core 1 writes 0x00000007 to 0x00000002 while core 3 idles -> mem_wren=1, mem_writedata=7, mem_address=2, stable through BUSY. core_response[1] pulses once.
- Reset mid-operation: assert reset_n=0 during BUSY, then pulse mem_response -> mem_request low on the reset edge, no core_response. rr_ptr=0 after release.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): core 0 reads, memory never responds -> after 8 BUSY cycles core_response=4'b0001, core_error=1, core_readdata=0xFFFFFFFF. Next pending core is served.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Round-robin arbiter that shares one memory port among NUM_CORES cores.
// Only one transaction is in flight at a time. The winner's command is latched
// onto the mem_* outputs, and the memory response is routed back to that core only.
// Each transaction passes IDLE -> BUSY -> DONE. DONE never grants, so a served
// core's stale request cannot win again before the core drops it.
// Optional feature: define ARB_TIMEOUT_EN to abort a BUSY transaction after
// TIMEOUT_CYCLES cycles without mem_response. The aborted completion is flagged
// on core_error and returns all-ones read data.
module mem_port_arbiter #(
   parameter int WIDTH          = 32,
   parameter int NUM_CORES      = 4,
   parameter int IDX_W          = 2,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic [NUM_CORES-1:0]       core_request,
   input  logic [NUM_CORES-1:0]       core_wren,
   input  logic [NUM_CORES*WIDTH-1:0] core_address,
   input  logic [NUM_CORES*WIDTH-1:0] core_writedata,
   output logic [WIDTH-1:0]           core_readdata,
   output logic [NUM_CORES-1:0]       core_response,
   output logic                       core_error,
   output logic                       mem_request,
   output logic                       mem_wren,
   output logic [WIDTH-1:0]           mem_address,
   output logic [WIDTH-1:0]           mem_writedata,
   input  logic [WIDTH-1:0]           mem_readdata,
   input  logic                       mem_response,
   output logic [IDX_W-1:0]           grant_idx,
   output logic                       busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CORES - 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [IDX_W-1:0] r_rr_ptr;
   logic [IDX_W-1:0] w_pick;
   logic             w_grant;
   logic             w_complete;
   logic             w_timeout;
   logic             w_tmo_hit;

   // First requesting core at or after ptr, searching upward with wrap-around.
   function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_CORES-1:0] req,
                                                input logic [IDX_W-1:0]     ptr);
      logic [IDX_W-1:0] pick;
      logic             found;
      int               idx;
      pick  = '0;
      found = 1'b0;
      for (int k = 0; k < NUM_CORES; k++) begin
         idx = (int'(ptr) + k) % NUM_CORES;
         if (!found && req[idx]) begin
            pick  = IDX_W'(idx);
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   // Pointer to the core after idx, wrapping at NUM_CORES.
   function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] idx);
      logic [IDX_W-1:0] nxt;
      if (idx == LAST_IDX) nxt = '0;
      else                 nxt = idx + 1'b1;
      return nxt;
   endfunction

   assign w_pick = rr_pick(core_request, r_rr_ptr);
   assign busy   = (r_state != S_IDLE);

`ifdef ARB_TIMEOUT_EN
   localparam int               TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   logic [TMO_W-1:0] r_tmo_cnt;

   // Count BUSY cycles since the grant; the last allowed cycle raises the timeout.
   always_ff @(posedge clk) begin
      if (!reset_n || w_grant) begin
         r_tmo_cnt <= '0;
      end else if (r_state == S_BUSY) begin
         r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
   end

   assign w_tmo_hit = (r_tmo_cnt == TMO_LAST);
`else
   logic w_unused_tmo;

   assign w_tmo_hit    = 1'b0;
   assign w_unused_tmo = ^TIMEOUT_CYCLES;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   // Next state plus one-cycle event strobes (grant, completion, timeout).
   always_comb begin
      w_state_nxt = r_state;
      w_grant     = 1'b0;
      w_complete  = 1'b0;
      w_timeout   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (|core_request) begin
               w_grant     = 1'b1;
               w_state_nxt = S_BUSY;
            end
         end
         S_BUSY: begin
            // A response on the timeout edge still counts as a normal completion.
            if (mem_response) begin
               w_complete  = 1'b1;
               w_state_nxt = S_DONE;
            end else if (w_tmo_hit) begin
               w_timeout   = 1'b1;
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Latch the winner's command, return the response to it, and advance the rr pointer.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_rr_ptr      <= '0;
         grant_idx     <= '0;
         mem_request   <= 1'b0;
         mem_wren      <= 1'b0;
         mem_address   <= '0;
         mem_writedata <= '0;
         core_readdata <= '0;
         core_response <= '0;
         core_error    <= 1'b0;
      end else begin
         core_response <= '0;
         core_error    <= 1'b0;
         if (w_grant) begin
            mem_request   <= 1'b1;
            mem_wren      <= core_wren[w_pick];
            mem_address   <= core_address[int'(w_pick)*WIDTH +: WIDTH];
            mem_writedata <= core_writedata[int'(w_pick)*WIDTH +: WIDTH];
            grant_idx     <= w_pick;
         end
         if (w_complete || w_timeout) begin
            mem_request              <= 1'b0;
            core_readdata            <= w_timeout ? {WIDTH{1'b1}} : mem_readdata;
            core_response[grant_idx] <= 1'b1;
            core_error               <= w_timeout;
            r_rr_ptr                 <= next_ptr(grant_idx);
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter (4 cores, 32-bit, TIMEOUT_CYCLES=8).
module tb_mem_port_arbiter;

   localparam int WIDTH = 32;
   localparam int NC    = 4;
   localparam int IDX_W = 2;

   logic             clk = 1'b0;
   logic             reset_n;
   logic [NC-1:0]    core_request;
   logic [NC-1:0]    core_wren;
   logic [NC*WIDTH-1:0] core_address;
   logic [NC*WIDTH-1:0] core_writedata;
   logic [WIDTH-1:0] core_readdata;
   logic [NC-1:0]    core_response;
   logic             core_error;
   logic             mem_request;
   logic             mem_wren;
   logic [WIDTH-1:0] mem_address;
   logic [WIDTH-1:0] mem_writedata;
   logic [WIDTH-1:0] mem_readdata;
   logic             mem_response;
   logic [IDX_W-1:0] grant_idx;
   logic             busy;

   int errors = 0;
   int checks = 0;

   mem_port_arbiter #(
      .WIDTH(WIDTH), .NUM_CORES(NC), .IDX_W(IDX_W), .TIMEOUT_CYCLES(8)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .core_request(core_request), .core_wren(core_wren),
      .core_address(core_address), .core_writedata(core_writedata),
      .core_readdata(core_readdata), .core_response(core_response),
      .core_error(core_error),
      .mem_request(mem_request), .mem_wren(mem_wren),
      .mem_address(mem_address), .mem_writedata(mem_writedata),
      .mem_readdata(mem_readdata), .mem_response(mem_response),
      .grant_idx(grant_idx), .busy(busy)
   );

   always #5 clk = ~clk;

   // Advance one rising edge; outputs are then sampled and inputs driven 1 time unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      reset_n        = 1'b0;
      core_request   = '0;
      core_wren      = '0;
      core_address   = '0;
      core_writedata = '0;
      mem_readdata   = '0;
      mem_response   = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      reset_n      = 1'b0;
      core_request = 4'b1111;
      core_address[0*WIDTH +: WIDTH] = 32'h100;
      tick();
      tick();
      checks++; if (mem_request !== 1'b0) begin errors++; $display("FAIL rst_mem_request: got %0b expected 0", mem_request); end
      checks++; if (core_response !== 4'b0000) begin errors++; $display("FAIL rst_core_response: got %b expected 0000", core_response); end
      checks++; if (grant_idx !== 2'd0) begin errors++; $display("FAIL rst_grant_idx: got %0d expected 0", grant_idx); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b expected 0", busy); end
      checks++; if (core_error !== 1'b0) begin errors++; $display("FAIL rst_core_error: got %0b expected 0", core_error); end
      reset_n = 1'b1;
      tick();
      checks++; if (mem_request !== 1'b1 || grant_idx !== 2'd0) begin errors++; $display("FAIL rst_first_grant: got req=%0b idx=%0d expected req=1 idx=0", mem_request, grant_idx); end
      checks++; if (mem_address !== 32'h100) begin errors++; $display("FAIL rst_first_addr: got %h expected 00000100", mem_address); end
   endtask

   task automatic test_single_read();
      apply_reset();
      core_request = 4'b0100;
      core_address[2*WIDTH +: WIDTH] = 32'h10;
      tick();
      checks++; if (mem_request !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL rd_request: got req=%0b busy=%0b expected 1 1", mem_request, busy); end
      checks++; if (mem_address !== 32'h10 || mem_wren !== 1'b0) begin errors++; $display("FAIL rd_cmd: got addr=%h wren=%0b expected 00000010 0", mem_address, mem_wren); end
      checks++; if (grant_idx !== 2'd2) begin errors++; $display("FAIL rd_grant: got %0d expected 2", grant_idx); end
      tick();
      tick();
      checks++; if (mem_request !== 1'b1 || mem_address !== 32'h10 || core_response !== 4'b0) begin errors++; $display("FAIL rd_hold: got req=%0b addr=%h resp=%b expected 1 00000010 0000", mem_request, mem_address, core_response); end
      mem_response = 1'b1;
      mem_readdata = 32'h2;
      tick();
      checks++; if (core_response !== 4'b0100) begin errors++; $display("FAIL rd_response: got %b expected 0100", core_response); end
      checks++; if (core_readdata !== 32'h2 || core_error !== 1'b0) begin errors++; $display("FAIL rd_data: got %h err=%0b expected 00000002 0", core_readdata, core_error); end
      checks++; if (mem_request !== 1'b0) begin errors++; $display("FAIL rd_req_drop: got %0b expected 0", mem_request); end
      core_request = 4'b0000;
      mem_response = 1'b0;
      mem_readdata = '0;
      tick();
      checks++; if (core_response !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL rd_one_cycle: got resp=%b busy=%0b expected 0000 0", core_response, busy); end
      // mem_response in IDLE must be ignored
      mem_response = 1'b1;
      tick();
      checks++; if (core_response !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL idle_resp_ignored: got resp=%b busy=%0b expected 0000 0", core_response, busy); end
      mem_response = 1'b0;
      // rr pointer is now 3; cores 0 and 1 request together -> wrap to 0 first
      core_request = 4'b0011;
      tick();
      checks++; if (grant_idx !== 2'd0) begin errors++; $display("FAIL rr_wrap: got %0d expected 0", grant_idx); end
      mem_response = 1'b1;
      tick();
      core_request[0] = 1'b0;
      mem_response    = 1'b0;
      tick();
      tick();
      checks++; if (grant_idx !== 2'd1 || mem_request !== 1'b1) begin errors++; $display("FAIL rr_next: got idx=%0d req=%0b expected 1 1", grant_idx, mem_request); end
      mem_response = 1'b1;
      tick();
      core_request = 4'b0000;
      mem_response = 1'b0;
      tick();
   endtask

   task automatic test_write();
      int stable_bad;
      int pulses;
      apply_reset();
      core_request = 4'b0010;
      core_wren    = 4'b0010;
      core_address[1*WIDTH +: WIDTH]   = 32'h2;
      core_writedata[1*WIDTH +: WIDTH] = 32'h7;
      core_address[3*WIDTH +: WIDTH]   = 32'hABC;
      tick();
      checks++; if (mem_wren !== 1'b1 || mem_writedata !== 32'h7 || mem_address !== 32'h2) begin errors++; $display("FAIL wr_cmd: got wren=%0b data=%h addr=%h expected 1 00000007 00000002", mem_wren, mem_writedata, mem_address); end
      checks++; if (grant_idx !== 2'd1) begin errors++; $display("FAIL wr_grant: got %0d expected 1", grant_idx); end
      stable_bad = 0;
      for (int c = 0; c < 4; c++) begin
         tick();
         if (mem_request !== 1'b1 || mem_wren !== 1'b1 || mem_writedata !== 32'h7 || mem_address !== 32'h2) stable_bad++;
      end
      checks++; if (stable_bad !== 0) begin errors++; $display("FAIL wr_stable: got %0d unstable cycles expected 0", stable_bad); end
      mem_response = 1'b1;
      pulses = 0;
      tick();
      if (core_response === 4'b0010) pulses++;
      core_request = 4'b0000;
      core_wren    = 4'b0000;
      mem_response = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick();
         if (core_response !== 4'b0000) pulses++;
      end
      checks++; if (pulses !== 1) begin errors++; $display("FAIL wr_pulse: got %0d pulses expected 1", pulses); end
   endtask

   task automatic test_round_robin();
      int got[5];
      int cnt[NC];
      int n;
      logic prev;
      apply_reset();
      for (int k = 0; k < 5; k++) got[k] = -1;
      for (int i = 0; i < NC; i++) cnt[i] = 0;
      n    = 0;
      prev = 1'b0;
      core_request = 4'b1111;
      for (int cyc = 0; cyc < 80 && n < 5; cyc++) begin
         tick();
         if (mem_request && !prev) begin
            got[n] = int'(grant_idx);
            n++;
         end
         prev = mem_request;
         for (int i = 0; i < NC; i++) begin
            if (core_response[i]) begin
               core_request[i] = 1'b0;
               cnt[i] = 2;
            end else if (cnt[i] > 0) begin
               cnt[i]--;
               if (cnt[i] == 0) core_request[i] = 1'b1;
            end
         end
         mem_response = mem_request;
      end
      checks++; if (n !== 5) begin errors++; $display("FAIL rr_count: got %0d grants expected 5", n); end
      for (int k = 0; k < 5; k++) begin
         checks++; if (got[k] !== k % NC) begin errors++; $display("FAIL rr_order[%0d]: got %0d expected %0d", k, got[k], k % NC); end
      end
      core_request = 4'b0000;
      mem_response = 1'b0;
   endtask

   task automatic test_reset_mid();
      apply_reset();
      core_request = 4'b0010;
      tick();
      mem_response = 1'b1;
      tick();
      core_request = 4'b0000;
      mem_response = 1'b0;
      tick();
      core_request = 4'b0100;
      tick();
      checks++; if (grant_idx !== 2'd2 || mem_request !== 1'b1) begin errors++; $display("FAIL mid_setup: got idx=%0d req=%0b expected 2 1", grant_idx, mem_request); end
      tick();
      reset_n = 1'b0;
      tick();
      checks++; if (mem_request !== 1'b0 || busy !== 1'b0 || core_response !== 4'b0) begin errors++; $display("FAIL mid_drop: got req=%0b busy=%0b resp=%b expected 0 0 0000", mem_request, busy, core_response); end
      mem_response = 1'b1;
      mem_readdata = 32'hDEAD;
      tick();
      checks++; if (core_response !== 4'b0 || core_readdata !== 32'h0) begin errors++; $display("FAIL mid_discard: got resp=%b data=%h expected 0000 00000000", core_response, core_readdata); end
      mem_response = 1'b0;
      reset_n      = 1'b1;
      core_request = 4'b1111;
      tick();
      checks++; if (grant_idx !== 2'd0 || mem_request !== 1'b1) begin errors++; $display("FAIL mid_rrptr: got idx=%0d req=%0b expected 0 1", grant_idx, mem_request); end
      core_request = 4'b0000;
   endtask

`ifdef ARB_TIMEOUT_EN
   task automatic test_timeout();
      int bad;
      apply_reset();
      core_request = 4'b0011;
      tick();
      checks++; if (grant_idx !== 2'd0) begin errors++; $display("FAIL tmo_grant0: got %0d expected 0", grant_idx); end
      bad = 0;
      for (int c = 0; c < 7; c++) begin
         tick();
         if (mem_request !== 1'b1 || core_response !== 4'b0) bad++;
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL tmo_wait: got %0d early cycles expected 0", bad); end
      tick();
      checks++; if (core_response !== 4'b0001 || core_error !== 1'b1) begin errors++; $display("FAIL tmo_pulse: got resp=%b err=%0b expected 0001 1", core_response, core_error); end
      checks++; if (core_readdata !== 32'hFFFFFFFF || mem_request !== 1'b0) begin errors++; $display("FAIL tmo_data: got %h req=%0b expected ffffffff 0", core_readdata, mem_request); end
      core_request[0] = 1'b0;
      tick();
      checks++; if (core_response !== 4'b0 || core_error !== 1'b0) begin errors++; $display("FAIL tmo_clear: got resp=%b err=%0b expected 0000 0", core_response, core_error); end
      tick();
      checks++; if (grant_idx !== 2'd1 || mem_request !== 1'b1) begin errors++; $display("FAIL tmo_next: got idx=%0d req=%0b expected 1 1", grant_idx, mem_request); end
      for (int c = 0; c < 7; c++) tick();
      mem_response = 1'b1;
      mem_readdata = 32'h55;
      tick();
      checks++; if (core_response !== 4'b0010 || core_error !== 1'b0 || core_readdata !== 32'h55) begin errors++; $display("FAIL tmo_tie: got resp=%b err=%0b data=%h expected 0010 0 00000055", core_response, core_error, core_readdata); end
      core_request = 4'b0000;
      mem_response = 1'b0;
      tick();
   endtask
`else
   task automatic test_no_timeout();
      int bad;
      apply_reset();
      core_request = 4'b0001;
      tick();
      bad = 0;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (mem_request !== 1'b1 || busy !== 1'b1 || core_response !== 4'b0) bad++;
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL notmo_wait: got %0d broken cycles expected 0", bad); end
      mem_response = 1'b1;
      mem_readdata = 32'h1234;
      tick();
      checks++; if (core_response !== 4'b0001 || core_error !== 1'b0 || core_readdata !== 32'h1234) begin errors++; $display("FAIL notmo_done: got resp=%b err=%0b data=%h expected 0001 0 00001234", core_response, core_error, core_readdata); end
      core_request = 4'b0000;
      mem_response = 1'b0;
      tick();
   endtask
`endif

   initial begin
      reset_n        = 1'b0;
      core_request   = '0;
      core_wren      = '0;
      core_address   = '0;
      core_writedata = '0;
      mem_readdata   = '0;
      mem_response   = 1'b0;
      test_reset();
      test_single_read();
      test_write();
      test_round_robin();
      test_reset_mid();
`ifdef ARB_TIMEOUT_EN
      test_timeout();
`else
      test_no_timeout();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
